apb_slave_ctrl: RTL and testbench

//  Parametrised APB3/APB4 slave front-end for the UART register file.

---
 rtl/uart_apb_pkg.sv | 19 +
 rtl/dff.sv | 20 ++
 rtl/apb_slave_ctrl.sv | 130 +++++++++++++
 tb/tb_apb_slave_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Purpose: shared types and constants for the UART APB slave front-end.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Largest programmable wait-state count; sized to the 4-bit wait counter.
  localparam int MAX_WAIT = 15;

  // Number of byte-offset bits below the register index for a bus width.
  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/dff.sv
// Purpose: generic flop bank with asynchronous active-low reset.
// Latency: 1 cycle d -> q.
// Backpressure: none; loads every cycle.
// Ports: clk, reset_b (async active-low), d/q [FLOP_WIDTH].
module dff #(
  parameter int                    FLOP_WIDTH = 1,
  parameter logic [FLOP_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [FLOP_WIDTH-1:0] d,
  output logic [FLOP_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) q <= RESET_VAL;
    else          q <= d;
  end

endmodule

// File: rtl/apb_slave_ctrl.sv
// Purpose: APB3/APB4 slave front-end for the UART register bank (decode, wait states, strobes, errors).
// Latency: setup + (WAIT_STATES+1) access cycles; strobes and prdata appear in the completion cycle.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop aborts without strobes.
// Ports: APB side pclk/preset_n/psel/penable/pwrite/paddr/pwdata/pstrb -> pready/prdata/pslverr;
//        bank side reg_idx/wr_en/wr_data/wr_strb/rd_en out, rdata_i in (combinational read data).
module apb_slave_ctrl
  import uart_apb_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  localparam int                 STRB_W      = DATA_WIDTH / 8,
  localparam int                 IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]     pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [IDX_W-1:0]      reg_idx,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_W-1:0]     wr_strb,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  localparam int                  ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int                  IDXF_W   = ADDR_WIDTH - ADDR_LSB;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
    $error("apb_slave_ctrl: DATA_WIDTH must be 8, 16 or 32");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("apb_slave_ctrl: WAIT_STATES out of range 0..MAX_WAIT");
  end
  if (NUM_REGS < 1 || NUM_REGS > (1 << IDXF_W)) begin : g_bad_regs
    $error("apb_slave_ctrl: NUM_REGS exceeds the decodable index space");
  end

  apb_state_e        state, state_d;
  logic [0:0]        state_q;
  logic [3:0]        wait_cnt;
  logic              write_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;

  logic [IDXF_W-1:0] paddr_idx;
  logic              out_of_range;
  logic              misaligned;
  logic              ro_hit;
  logic              setup_err;
  logic              setup_acc;
  logic              completion;

  assign paddr_idx    = paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign out_of_range = (int'(paddr_idx) >= NUM_REGS);
  assign misaligned   = |(paddr & LSB_MASK);

  // Loop compare keeps RO_MASK lookups in range even for out-of-range indices.
  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(paddr_idx) == i) ro_hit = RO_MASK[i];
    end
  end

  assign setup_err  = out_of_range | misaligned | (pwrite & ro_hit);
  assign setup_acc  = (state == IDLE) && psel && !penable;
  assign completion = (state == ACCESS) && (wait_cnt == '0) && psel && penable;

  // penable seen in IDLE is a protocol violation and is simply ignored.
  always_comb begin
    state_d = state;
    if (state == IDLE) begin
      if (psel && !penable) state_d = ACCESS;
    end else begin
      if (!psel)                          state_d = IDLE;
      else if (wait_cnt == '0 && penable) state_d = IDLE;
    end
  end

  dff #(.FLOP_WIDTH(1)) u_state (
    .clk     (pclk),
    .reset_b (preset_n),
    .d       (state_d),
    .q       (state_q)
  );
  assign state = apb_state_e'(state_q);

  // Transfer attributes are captured at the setup edge so the access phase
  // does not depend on the master holding paddr/pwrite stable.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else if (setup_acc) begin
      wait_cnt <= 4'(WAIT_STATES);
      write_q  <= pwrite;
      err_q    <= setup_err;
      idx_q    <= (NUM_REGS > 1) ? paddr_idx[IDX_W-1:0] : '0;
    end else if (state == ACCESS) begin
      if (!psel)                wait_cnt <= '0;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Strobes and response are decoded from the completion cycle so the bank
  // sees exactly one strobe and can return rdata_i in the same cycle.
  assign pready  = !((state == ACCESS) && (wait_cnt != '0));
  assign pslverr = completion & err_q;
  assign wr_en   = completion & !err_q & write_q;
  assign rd_en   = completion & !err_q & !write_q;
  assign wr_data = pwdata;
  assign wr_strb = wr_en ? pstrb : '0;
  assign prdata  = rd_en ? rdata_i : '0;
  assign reg_idx = idx_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Purpose: self-checking bench for apb_slave_ctrl over three parameter sets sharing one APB bus.
// Latency: n/a.
// Backpressure: master holds the access phase until the selected slave raises pready.
module tb_apb_slave_ctrl;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, rdata_i;
  logic [3:0]  pstrb;

  logic        pready_a[3], pslverr_a[3], wr_en_a[3], rd_en_a[3];
  logic [31:0] prdata_a[3], wr_data_a[3];
  logic [3:0]  wr_strb_a[3];
  logic [2:0]  reg_idx_a[3];

  int          sel = 0;
  logic        o_pready, o_pslverr, o_wr_en, o_rd_en;
  logic [31:0] o_prdata, o_wr_data;
  logic [3:0]  o_wr_strb;
  logic [2:0]  o_reg_idx;

  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          comp_cycle = 0;

  // Reference configuration of each slave instance.
  int          waits[3] = '{0, 3, 2};
  logic [7:0]  ros[3]   = '{8'h00, 8'h00, 8'h02};

  always #5 pclk = ~pclk;
  always @(posedge pclk) cycle <= cycle + 1;

  apb_slave_ctrl #(.WAIT_STATES(0), .RO_MASK(8'h00)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[0]), .prdata(prdata_a[0]),
    .pslverr(pslverr_a[0]), .reg_idx(reg_idx_a[0]), .wr_en(wr_en_a[0]), .wr_data(wr_data_a[0]),
    .wr_strb(wr_strb_a[0]), .rd_en(rd_en_a[0]), .rdata_i(rdata_i));

  apb_slave_ctrl #(.WAIT_STATES(3), .RO_MASK(8'h00)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[1]), .prdata(prdata_a[1]),
    .pslverr(pslverr_a[1]), .reg_idx(reg_idx_a[1]), .wr_en(wr_en_a[1]), .wr_data(wr_data_a[1]),
    .wr_strb(wr_strb_a[1]), .rd_en(rd_en_a[1]), .rdata_i(rdata_i));

  apb_slave_ctrl #(.WAIT_STATES(2), .RO_MASK(8'h02)) u_dut2 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready_a[2]), .prdata(prdata_a[2]),
    .pslverr(pslverr_a[2]), .reg_idx(reg_idx_a[2]), .wr_en(wr_en_a[2]), .wr_data(wr_data_a[2]),
    .wr_strb(wr_strb_a[2]), .rd_en(rd_en_a[2]), .rdata_i(rdata_i));

  always_comb begin
    o_pready  = pready_a[sel];
    o_pslverr = pslverr_a[sel];
    o_wr_en   = wr_en_a[sel];
    o_rd_en   = rd_en_a[sel];
    o_prdata  = prdata_a[sel];
    o_wr_data = wr_data_a[sel];
    o_wr_strb = wr_strb_a[sel];
    o_reg_idx = reg_idx_a[sel];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut=%0d observed=0x%0h expected=0x%0h", tag, sel, obs, exp);
    end
  endtask

  // Error rule stated on byte addresses: 4-byte registers, 8 of them.
  function automatic bit exp_err(input logic [7:0] a, input bit w, input logic [7:0] ro);
    int idx;
    idx = int'(a) / 4;
    return (idx >= 8) || ((int'(a) % 4) != 0) || (w && idx < 8 && ro[idx[2:0]]);
  endfunction

  task automatic check_reset_vals(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check({tag, "_pready"},  32'(o_pready), 32'd1);
      check({tag, "_strobes"}, {29'd0, o_wr_en, o_rd_en, o_pslverr}, 32'd0);
      check({tag, "_prdata"},  o_prdata, 32'd0);
      check({tag, "_reg_idx"}, 32'(o_reg_idx), 32'd0);
    end
  endtask

  task automatic xfer(input int s, input logic [7:0] a, input bit w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd, input bit idle_first);
    bit err;
    int n;
    sel = s;
    err = exp_err(a, w, ros[s]);
    if (idle_first) begin
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      #1 check("idle_strobes", {30'd0, o_wr_en, o_rd_en}, 32'd0);
    end
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st; rdata_i = rd;
    #1 check("setup_strobes", {30'd0, o_wr_en, o_rd_en}, 32'd0);
    @(negedge pclk);
    penable = 1'b1;
    #1;
    n = 0;
    while (!o_pready && n < 20) begin
      check("wait_strobes", {29'd0, o_wr_en, o_rd_en, o_pslverr}, 32'd0);
      @(negedge pclk);
      #1;
      n++;
    end
    comp_cycle = cycle;
    check("pready",     32'(o_pready), 32'd1);
    check("wait_count", 32'(n), 32'(waits[s]));
    check("pslverr",    32'(o_pslverr), 32'(err));
    check("wr_en",      32'(o_wr_en), 32'(w && !err));
    check("rd_en",      32'(o_rd_en), 32'(!w && !err));
    check("wr_strb",    32'(o_wr_strb), (w && !err) ? 32'(st) : 32'd0);
    check("prdata",     o_prdata, (!w && !err) ? rd : 32'd0);
    check("wr_data",    o_wr_data, wd);
    if (!err) check("reg_idx", 32'(o_reg_idx), 32'(a) / 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int last_sel;
    logic [7:0] a;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; rdata_i = '0;
    preset_n = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge pclk);
    preset_n = 1'b1;

    // Basic write, waited read, bad accesses, read-only register.
    xfer(0, 8'h04, 1'b1, 32'hA5A5_0001, 4'hF, 32'h0, 1'b1);
    xfer(1, 8'h08, 1'b0, 32'h0, 4'h0, 32'h0000_1234, 1'b1);
    xfer(0, 8'h40, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1);
    xfer(0, 8'h05, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0, 1'b0);
    xfer(2, 8'h04, 1'b1, 32'h0BAD_0BAD, 4'hF, 32'h0, 1'b1);
    xfer(2, 8'h04, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // Back-to-back with no idle cycle between transfers.
    xfer(0, 8'h00, 1'b1, 32'h1111_2222, 4'h5, 32'h0, 1'b1);
    t1 = comp_cycle;
    xfer(0, 8'h0C, 1'b0, 32'h0, 4'h0, 32'h3333_4444, 1'b0);
    check("b2b_spacing", 32'(comp_cycle - t1), 32'd2);

    // Abort by dropping psel mid-wait.
    sel = 2;
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    @(negedge pclk); psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pstrb = 4'hF;
    @(negedge pclk); penable = 1'b1;
    #1 check("abort_wait_pready", 32'(o_pready), 32'd0);
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    #1 check("abort_strobes", {30'd0, o_wr_en, o_rd_en}, 32'd0);
    @(negedge pclk);
    #1 check("abort_idle_pready", 32'(o_pready), 32'd1);
    check("abort_idle_strobes", {30'd0, o_wr_en, o_rd_en}, 32'd0);
    xfer(2, 8'h0C, 1'b1, 32'h5555_AAAA, 4'h9, 32'h0, 1'b0);

    // Reset pulse in the middle of an access phase.
    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    @(negedge pclk); psel = 1'b1; pwrite = 1'b0; paddr = 8'h08;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); preset_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge pclk);
    #1 check_reset_vals("midreset_hold");
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); preset_n = 1'b1;
    xfer(2, 8'h18, 1'b0, 32'h0, 4'h0, 32'h7777_8888, 1'b0);

    // Randomised transfers across all three slaves.
    last_sel = 2;
    for (int k = 0; k < 60; k++) begin
      int s;
      s = int'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) a = 8'($urandom_range(0, 7) * 4);
      else                          a = 8'($urandom);
      xfer(s, a, 1'($urandom), $urandom, 4'($urandom), $urandom,
           (s != last_sel) || 1'($urandom));
      last_sel = s;
    end

    @(negedge pclk); psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
